// File: rtl/cmd_burst_exec.sv
// Command burst executor: queues chunk commands in a small FIFO and plays each one
// out as BEAT_BYTES-wide bus beats. Define CMD_BURST_STATS_EN to add completion counters.
module cmd_burst_exec #(
    parameter int ADDRW      = 32,
    parameter int BYTE_CNTw  = 16,
    parameter int BEAT_BYTES = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  wr,
    input  logic [BYTE_CNTw-1:0]  byte_cnt,
    input  logic [ADDRW-1:0]      start_addr,
    output logic                  req_ack,
    output logic                  done,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic [ADDRW-1:0]      bus_addr,
    output logic                  bus_wr,
    output logic [BEAT_BYTES-1:0] bus_be,
    output logic                  bus_last,
    output logic                  busy
`ifdef CMD_BURST_STATS_EN
    ,
    output logic [31:0]           stat_cmds,
    output logic [31:0]           stat_bytes
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [BYTE_CNTw-1:0] BEAT_CNT  = BYTE_CNTw'(BEAT_BYTES);
    localparam logic [ADDRW-1:0]     BEAT_STEP = ADDRW'(BEAT_BYTES);
    localparam logic [ADDRW-1:0]     ALIGN_MASK = ~ADDRW'(BEAT_BYTES - 1);

    logic                 mem_wr   [FIFO_DEPTH];
    logic [BYTE_CNTw-1:0] mem_cnt  [FIFO_DEPTH];
    logic [ADDRW-1:0]     mem_addr [FIFO_DEPTH];

    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [1:0]           state;
    logic [ADDRW-1:0]     addr_r;
    logic [BYTE_CNTw-1:0] rem_r;
    logic                 wr_r;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic beat_last;
    logic handshake;

    // Pointers carry a wrap bit so full and empty are distinguishable without a counter.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign req_ack   = req & ~full & ~rst;
    assign push      = req_ack & (byte_cnt != '0);
    assign pop       = (state == ST_IDLE) & ~empty;
    assign beat_last = (rem_r <= BEAT_CNT);
    assign handshake = bus_valid & bus_ready;

    assign bus_valid = (state == ST_BURST);
    assign bus_addr  = bus_valid ? addr_r : '0;
    assign bus_wr    = bus_valid & wr_r;
    assign bus_last  = bus_valid & beat_last;
    assign done      = (state == ST_DONE);
    assign busy      = ~empty | (state != ST_IDLE);

    always_comb begin
        bus_be = '0;
        if (bus_valid) begin
            if (beat_last) begin
                for (int i = 0; i < BEAT_BYTES; i++) begin
                    bus_be[i] = (BYTE_CNTw'(i) < rem_r);
                end
            end else begin
                bus_be = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_wr[wr_ptr[AW-1:0]]   <= wr;
            mem_cnt[wr_ptr[AW-1:0]]  <= byte_cnt;
            mem_addr[wr_ptr[AW-1:0]] <= start_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            addr_r <= '0;
            rem_r  <= '0;
            wr_r   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        addr_r <= mem_addr[rd_ptr[AW-1:0]] & ALIGN_MASK;
                        rem_r  <= mem_cnt[rd_ptr[AW-1:0]];
                        wr_r   <= mem_wr[rd_ptr[AW-1:0]];
                        state  <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (handshake) begin
                        addr_r <= addr_r + BEAT_STEP;
                        rem_r  <= rem_r - (beat_last ? rem_r : BEAT_CNT);
                        if (beat_last) state <= ST_DONE;
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

`ifdef CMD_BURST_STATS_EN
    logic [BYTE_CNTw-1:0] cnt_r;

    // The original chunk length is kept alongside rem_r so it can be credited on done.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= '0;
            stat_cmds  <= '0;
            stat_bytes <= '0;
        end else begin
            if (pop) cnt_r <= mem_cnt[rd_ptr[AW-1:0]];
            if (state == ST_DONE) begin
                stat_cmds  <= stat_cmds + 32'd1;
                stat_bytes <= stat_bytes + 32'(cnt_r);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cmd_burst_exec.sv
// Self-checking bench for cmd_burst_exec: directed plan steps plus a random phase,
// all beats and done pulses compared against a chunk-level reference model.
module tb_cmd_burst_exec;

    localparam int ADDRW = 32;
    localparam int BCW   = 16;
    localparam int BB    = 4;
    localparam int FD    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req;
    logic              wr;
    logic [BCW-1:0]    byte_cnt;
    logic [ADDRW-1:0]  start_addr;
    logic              req_ack;
    logic              done;
    logic              bus_valid;
    logic              bus_ready;
    logic [ADDRW-1:0]  bus_addr;
    logic              bus_wr;
    logic [BB-1:0]     bus_be;
    logic              bus_last;
    logic              busy;
`ifdef CMD_BURST_STATS_EN
    logic [31:0]       stat_cmds;
    logic [31:0]       stat_bytes;
`endif

    cmd_burst_exec #(
        .ADDRW(ADDRW), .BYTE_CNTw(BCW), .BEAT_BYTES(BB), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .byte_cnt(byte_cnt),
        .start_addr(start_addr), .req_ack(req_ack), .done(done),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_wr(bus_wr), .bus_be(bus_be), .bus_last(bus_last), .busy(busy)
`ifdef CMD_BURST_STATS_EN
        , .stat_cmds(stat_cmds), .stat_bytes(stat_bytes)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDRW-1:0] addr;
        logic [BB-1:0]    be;
        logic             last;
        logic             wr;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned bytes_q[$];
    int          checks = 0;
    int          fails  = 0;
    bit          done_pending = 0;
    int          beats_seen = 0;
    int          dones_seen = 0;
    int          acks_seen  = 0;
    logic        ack_s;
    logic [31:0] stat_cmds_exp  = 0;
    logic [31:0] stat_bytes_exp = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // A chunk becomes ceil(n/BB) beats from the aligned base; only the final beat is partial.
    function automatic void modelChunk(input logic w, input int unsigned n, input logic [ADDRW-1:0] a);
        logic [ADDRW-1:0] base;
        int nb;
        base = a & ~32'(BB - 1);
        nb = (n + BB - 1) / BB;
        for (int i = 0; i < nb; i++) begin
            beat_t b;
            int left;
            left   = int'(n) - i * BB;
            b.addr = base + 32'(i * BB);
            b.last = (i == nb - 1);
            b.be   = b.last ? 4'((1 << left) - 1) : 4'hF;
            b.wr   = w;
            exp_q.push_back(b);
        end
        bytes_q.push_back(n);
    endfunction

    task automatic applyStimulus(input logic r, input logic w, input int unsigned n,
                                 input logic [ADDRW-1:0] a, input logic rdy);
        req        = r;
        wr         = w;
        byte_cnt   = BCW'(n);
        start_addr = a;
        bus_ready  = rdy;
    endtask

    // One clock: sample and score at negedge, return #1 after the next rising edge.
    task automatic cycle();
        bit new_pending;
        @(negedge clk);
        ack_s = req_ack;
        if (rst) begin
            exp_q.delete();
            bytes_q.delete();
            done_pending   = 0;
            stat_cmds_exp  = 0;
            stat_bytes_exp = 0;
        end else begin
            new_pending = 0;
            checkOutput("done", 64'(done), 64'(done_pending));
            if (done) dones_seen++;
            if (bus_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_beat", 64'(bus_valid), 64'(0));
                end else begin
                    checkOutput("bus_addr", 64'(bus_addr), 64'(exp_q[0].addr));
                    checkOutput("bus_be",   64'(bus_be),   64'(exp_q[0].be));
                    checkOutput("bus_last", 64'(bus_last), 64'(exp_q[0].last));
                    checkOutput("bus_wr",   64'(bus_wr),   64'(exp_q[0].wr));
                    if (bus_ready) begin
                        if (exp_q[0].last) begin
                            new_pending = 1;
                            stat_cmds_exp  = stat_cmds_exp + 32'd1;
                            stat_bytes_exp = stat_bytes_exp + 32'(bytes_q.pop_front());
                        end
                        void'(exp_q.pop_front());
                        beats_seen++;
                    end
                end
            end
            done_pending = new_pending;
            if (req_ack) begin
                acks_seen++;
                if (byte_cnt != '0) modelChunk(wr, byte_cnt, start_addr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high, 1: random ready, 2: ready toggles 1,0,1,0...
    task automatic drain(input int budget, input int mode);
        int k = 0;
        req = 1'b0;
        while ((exp_q.size() != 0 || done_pending) && k < budget) begin
            bus_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : ~k[0];
            cycle();
            k++;
        end
        checkOutput("drain_complete", 64'(exp_q.size() == 0 && !done_pending), 64'(1));
        checkOutput("busy_after_drain", 64'(busy), 64'(0));
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_valid"}, 64'(bus_valid), 64'(0));
        checkOutput({tag, "_done"},  64'(done),      64'(0));
        checkOutput({tag, "_busy"},  64'(busy),      64'(0));
        checkOutput({tag, "_addr"},  64'(bus_addr),  64'(0));
        checkOutput({tag, "_be"},    64'(bus_be),    64'(0));
        checkOutput({tag, "_last"},  64'(bus_last),  64'(0));
        checkOutput({tag, "_wr"},    64'(bus_wr),    64'(0));
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base_beats, base_dones, base_acks;

        // Reset state
        doReset();
        checkQuiet("reset");
        checkOutput("reset_req_ack", 64'(req_ack), 64'(0));

        // 512 bytes at 0x1000, write, ready high; first beat two cycles after ack
        base_beats = beats_seen; base_dones = dones_seen;
        applyStimulus(1, 1, 512, 32'h1000, 1);
        cycle();
        checkOutput("ack_512", 64'(ack_s), 64'(1));
        req = 1'b0;
        checkOutput("pop_cycle_valid", 64'(bus_valid), 64'(0));
        checkOutput("pop_cycle_busy",  64'(busy),      64'(1));
        cycle();
        checkOutput("first_beat_valid", 64'(bus_valid), 64'(1));
        drain(400, 0);
        checkOutput("beats_512", 64'(beats_seen - base_beats), 64'(128));
        checkOutput("dones_512", 64'(dones_seen - base_dones), 64'(1));

        // 7 bytes at unaligned 0x2003
        base_beats = beats_seen; base_dones = dones_seen;
        applyStimulus(1, 0, 7, 32'h2003, 1);
        cycle();
        checkOutput("ack_7", 64'(ack_s), 64'(1));
        drain(50, 0);
        checkOutput("beats_7", 64'(beats_seen - base_beats), 64'(2));
        checkOutput("dones_7", 64'(dones_seen - base_dones), 64'(1));

        // Capacity: ready low, req held 8 cycles -> FIFO_DEPTH+1 acks
        base_beats = beats_seen; base_dones = dones_seen; base_acks = acks_seen;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1, 32, 32'h4000 + 32'(i * 64), 0);
            cycle();
            checkOutput($sformatf("cap_ack_%0d", i), 64'(ack_s), 64'(i < FD + 1));
        end
        checkOutput("cap_acks", 64'(acks_seen - base_acks), 64'(FD + 1));
        drain(200, 0);
        checkOutput("cap_beats", 64'(beats_seen - base_beats), 64'(40));
        checkOutput("cap_dones", 64'(dones_seen - base_dones), 64'(5));

        // Backpressure with toggling ready
        base_beats = beats_seen; base_dones = dones_seen;
        applyStimulus(1, 1, 16, 32'h40, 0);
        cycle();
        drain(60, 2);
        checkOutput("toggle_beats", 64'(beats_seen - base_beats), 64'(4));
        checkOutput("toggle_dones", 64'(dones_seen - base_dones), 64'(1));

        // Reset mid-burst at beat 3 with two more chunks queued
        applyStimulus(1, 1, 64, 32'h3000, 0);
        cycle();
        applyStimulus(1, 0, 16, 32'h5000, 0);
        cycle();
        applyStimulus(1, 1, 16, 32'h6000, 0);
        cycle();
        req = 1'b0;
        cycle();
        base_beats = beats_seen;
        for (int k = 0; k < 20 && (beats_seen - base_beats) < 3; k++) begin
            bus_ready = 1'b1;
            cycle();
        end
        checkOutput("pre_reset_beats", 64'(beats_seen - base_beats), 64'(3));
        rst = 1'b1;
        bus_ready = 1'b0;
        cycle();
        rst = 1'b0;
        checkQuiet("midreset");
        base_dones = dones_seen;
        bus_ready = 1'b1;
        for (int k = 0; k < 10; k++) cycle();
        checkOutput("no_done_after_reset", 64'(dones_seen - base_dones), 64'(0));
        checkQuiet("post_reset_idle");
        applyStimulus(1, 1, 4, 32'h7000, 1);
        cycle();
        checkOutput("ack_after_reset", 64'(ack_s), 64'(1));
        drain(20, 0);
        checkOutput("dones_after_reset", 64'(dones_seen - base_dones), 64'(1));

        // Random traffic including zero-length chunks and random backpressure
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 40), $urandom, 1'($urandom_range(0, 1)));
            cycle();
        end
        drain(3000, 1);

        // Completion statistics over chunks 512, 7, 0, 32
        doReset();
        applyStimulus(1, 1, 512, 32'h1000, 1);
        cycle();
        drain(400, 0);
        applyStimulus(1, 0, 7, 32'h2003, 1);
        cycle();
        drain(50, 0);
        applyStimulus(1, 1, 0, 32'h8000, 1);
        cycle();
        checkOutput("ack_zero_len", 64'(ack_s), 64'(1));
        drain(20, 0);
        applyStimulus(1, 1, 32, 32'h9000, 1);
        cycle();
        drain(50, 0);
`ifdef CMD_BURST_STATS_EN
        checkOutput("stat_cmds",  64'(stat_cmds),  64'(stat_cmds_exp));
        checkOutput("stat_bytes", 64'(stat_bytes), 64'(stat_bytes_exp));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
